// File: rtl/imem_word_reader.sv
// Reads big-endian 32-bit words byte by byte from a synchronous byte memory and streams them out.
// Optional IMEM_READER_CHECKSUM_EN adds a running 32-bit sum of the handshaken words.
module imem_word_reader #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [31:0]       word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              done
`ifdef IMEM_READER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [1:0] {StIdle, StRead, StWait, StOut} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              rd_dly_q, rd_dly_d;
    logic [31:0]       word_q, word_d;
    logic              done_q, done_d;
    logic [31:0]       sum_q, sum_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            rd_dly_q   <= 1'b0;
            word_q     <= '0;
            done_q     <= 1'b0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            rd_dly_q   <= rd_dly_d;
            word_q     <= word_d;
            done_q     <= done_d;
            sum_q      <= sum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        done_d     = 1'b0;
        sum_d      = sum_q;
        // Memory data arrives one cycle after each read strobe.
        rd_dly_d   = mem_rd_q;
        word_d     = rd_dly_q ? {word_q[23:0], mem_data} : word_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (word_count != '0) begin
                        ptr_d      = base_addr;
                        cnt_d      = word_count;
                        idx_d      = '0;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = base_addr;
                        sum_d      = '0;
                        state_d    = StRead;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRead: begin
                if (idx_q == 2'd3) begin
                    state_d = StWait;
                end else begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    idx_d      = idx_q + 2'd1;
                end
            end
            StWait: begin
                state_d = StOut;
            end
            StOut: begin
                if (word_ready) begin
                    ptr_d = ptr_q + ADDR_W'(4);
                    cnt_d = cnt_q - CNT_W'(1);
                    sum_d = sum_q + word_q;
                    if (cnt_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d      = '0;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = ptr_q + ADDR_W'(4);
                        state_d    = StRead;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign word_out   = word_q;
    assign word_valid = (state_q == StOut);
    assign busy       = (state_q != StIdle);
    assign done       = done_q;

`ifdef IMEM_READER_CHECKSUM_EN
    assign checksum = sum_q;
`else
    logic unused_sum;
    assign unused_sum = ^sum_q;
`endif

endmodule

// File: doc/imem_word_reader.md
Name: imem_word_reader

Overview:
- Read-side counterpart to the bench byte loader, which fills the 512-byte instruction/data memory one byte per entry.
- Walks a region of that memory byte by byte and reassembles big-endian 32-bit MIPS words (byte at lowest address is the MSB).
- Streams the words out over a valid/ready handshake.
- Used by the processor bench to read back and check loaded program images and post-run memory contents.

Parameters:
- ADDR_W, 9, byte address width; memory depth is 2**ADDR_W bytes (512).
- CNT_W, 8, width of the word_count request field (max 255 words per request).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state.
- start  input  1  request strobe; sampled only in IDLE.
- base_addr  input  ADDR_W  first byte address; any alignment is allowed.
- word_count  input  CNT_W  number of 32-bit words to read.
- mem_rd  output  1  byte read enable to memory.
- mem_addr  output  ADDR_W  byte read address.
- mem_data  input  8  read data; synchronous memory, valid the cycle after mem_rd.
- word_out  output  32  assembled word {b0,b1,b2,b3}.
- word_valid  output  1  word_out holds a word.
- word_ready  input  1  consumer accepts the word.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when the request completes.

Behaviour:
- Reset (reset=0, async): state=IDLE; mem_rd=0, mem_addr=0, word_out=0, word_valid=0, busy=0, done=0; address pointer and word counter cleared.
- IDLE:
  - On a clock edge with start=1 and word_count!=0: latch base_addr into the pointer and word_count into the counter, set busy=1, go to READ.
  - On a clock edge with start=1 and word_count==0: done=1 for the next cycle only, busy stays 0, no reads issued.
- READ, 4 cycles:
  - mem_rd=1 each cycle; mem_addr = pointer, pointer+1, pointer+2, pointer+3.
  - Each address wraps modulo 2**ADDR_W (511 -> 0).
  - The byte returned for read k is shifted into word_out at the end of cycle k+1.
  - After the 4th read cycle, go to WAIT for one cycle with mem_rd=0 to capture the last byte, then go to OUT.
- Latency: start sampled at edge 0, reads occur in cycles 1-4, word_valid=1 from cycle 6.
- OUT:
  - word_valid=1; word_out is held stable while word_ready=0 (no change, no reads).
  - On an edge with word_valid & word_ready: pointer += 4 (mod depth), counter -= 1.
  - If the counter becomes 0: go to IDLE, busy=0, done=1 for one cycle. Otherwise go to READ.
  - word_valid drops for the read gap; there is no read-ahead.
- word_ready already high when word_valid rises: the handshake completes in that first valid cycle.
- start while busy: ignored; the request in flight is unaffected.
- base_addr/word_count changing after acceptance: no effect.
- reset asserted mid-request: immediate abort to the reset state; no done pulse.
- Throughput: 6 cycles per word with no backpressure.
- mem_addr holds its last value when mem_rd=0.

Optional Feature:
- Macro: IMEM_READER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum[31:0], reset to 0.
  - Cleared when a request is accepted.
  - On each word handshake: checksum <= checksum + word_out, modulo 2**32.
  - Final value is valid while done=1 and holds until the next accepted start.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic read:
  - Stimulus: memory bytes 0-7 = 8C,01,00,04,AC,22,00,08; base=0, count=2, word_ready held 1.
  - Response: words 8C010004 then AC220008; word_valid first high 6 cycles after the start edge; one done pulse; busy low afterwards.
- Wrap-around:
  - Stimulus: bytes 510,511,0,1 = 12,34,56,78; base=510, count=1.
  - Response: mem_addr sequence 510,511,0,1; word 12345678.
- Backpressure:
  - Stimulus: word_ready=0 for 10 cycles after word_valid rises, then 1.
  - Response: word_out and word_valid stable throughout; mem_rd=0 during the stall; exactly one handshake.
- Zero count and start-while-busy:
  - Stimulus: count=0.
  - Response: done pulse next cycle, no mem_rd.
  - Stimulus: a second start mid-request with a different base.
  - Response: ignored; the output word sequence is unchanged.
- Reset mid-request:
  - Stimulus: reset=0 during the 3rd READ cycle of word 2 of 4.
  - Response: all outputs 0 immediately, no done pulse.
  - Stimulus: new request after reset release.
  - Response: completes correctly.
- Checksum (IMEM_READER_CHECKSUM_EN):
  - Stimulus: words FFFFFFFF, 00000002.
  - Response: checksum=00000001 at done.
